// File: rtl/control_pipeline_pkg.sv
// rtl/control_pipeline_pkg.sv - shared encodings for the control pipeline
package control_pipeline_pkg;

  // Result select: which value the W stage writes back
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand source select
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // The younger producer (M) always wins over the older one (W)
  function automatic logic [1:0] forward_select(input logic m_hit, input logic w_hit);
    if (m_hit) begin
      return FWD_M;
    end else if (w_hit) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/control_pipeline_hazard_unit.sv
// rtl/control_pipeline_hazard_unit.sv - combinational stall, flush and forwarding decisions
module hazard_unit
  import control_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic                  ZeroE,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  output logic                  lwStall,
  output logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
);

  logic m_live;
  logic w_live;

  // x0 is hard-wired zero, so a write to it never creates a dependency
  assign m_live = RegWriteM && (RdM != '0);
  assign w_live = RegWriteW && (RdW != '0);

  // Load in E whose result is needed by the instruction in D: hold F/D, bubble E
  always_comb begin
    lwStall = 1'b0;
    if ((ResultSrcE == RESULT_MEM) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))) begin
      lwStall = 1'b1;
    end
  end

  assign PCSrcE = JumpE | (BranchE & ZeroE);
  assign StallF = lwStall;
  assign StallD = lwStall;
  assign FlushD = PCSrcE;
  assign FlushE = lwStall | PCSrcE;

  // Operand bypass from the nearest stage still holding an unwritten result
  always_comb begin
    ForwardAE = forward_select(m_live && (RdM == Rs1E), w_live && (RdW == Rs1E));
    ForwardBE = forward_select(m_live && (RdM == Rs2E), w_live && (RdW == Rs2E));
  end

endmodule

// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - E/M/W control registers, hazard steering and event counters
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [1:0]            ResultSrcD,
  input  logic [1:0]            ALUOpD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  ZeroE,
  output logic                  ALUSrcE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic [1:0]            ALUOpE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  logic       RegWriteE;
  logic       MemWriteE;
  logic [1:0] ResultSrcE;
  logic       lwStall;

  hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .ResultSrcE(ResultSrcE),
    .JumpE     (JumpE),
    .BranchE   (BranchE),
    .ZeroE     (ZeroE),
    .RegWriteM (RegWriteM),
    .RdM       (RdM),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .lwStall   (lwStall),
    .PCSrcE    (PCSrcE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  // D->E register: a flush inserts an all-zero bubble in place of the decoded instruction
  always_ff @(posedge clk) begin
    if (!rst_n || FlushE) begin
      RegWriteE  <= 1'b0;
      MemWriteE  <= 1'b0;
      JumpE      <= 1'b0;
      BranchE    <= 1'b0;
      ALUSrcE    <= 1'b0;
      ResultSrcE <= RESULT_ALU;
      ALUOpE     <= ALUOP_ADD;
      Rs1E       <= '0;
      Rs2E       <= '0;
      RdE        <= '0;
    end else begin
      RegWriteE  <= RegWriteD;
      MemWriteE  <= MemWriteD;
      JumpE      <= JumpD;
      BranchE    <= BranchD;
      ALUSrcE    <= ALUSrcD;
      ResultSrcE <= ResultSrcD;
      ALUOpE     <= ALUOpD;
      Rs1E       <= Rs1D;
      Rs2E       <= Rs2D;
      RdE        <= RdD;
    end
  end

  // E->M and M->W registers advance every cycle; nothing downstream of E ever stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= RESULT_ALU;
      RdM        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= RESULT_ALU;
      RdW        <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
    end
  end

  // Saturating counts of load-use stall cycles and taken-redirect cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (lwStall && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (PCSrcE && (FlushCount != '1)) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule
